rv32m_div_unit: RTL and testbench
=================================

Name: rv32m_div_unit

Overview:
- Iterative radix-2 divide/remainder unit in the EX stage, beside the single-cycle ALU.
- Consumes the 5-bit ALU opcode produced by the control unit, plus the two EX operands.
- Executes DIV/DIVU/REM/REMU over multiple cycles and presents a registered 32-bit result with a one-cycle done pulse.
- Pipeline hazard logic stalls EX while ready=0.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- OP_DIV, 5'b01000, ALU opcode for DIV.
- OP_DIVU, 5'b01001, ALU opcode for DIVU.
- OP_REM, 5'b01010, ALU opcode for REM.
- OP_REMU, 5'b01011, ALU opcode for REMU.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- alu_opcode  input  5  operation select, captured with start.
- operand_a  input  32  dividend (rs1), captured with start.
- operand_b  input  32  divisor (rs2), captured with start.
- flush  input  1  synchronous kill of any in-flight operation.
- ready  output  1  high only in IDLE.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  32  registered quotient or remainder; held until the next done.

Behaviour:
- Interface decision: one clock (CLK); RESET is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, internal counter/registers=0. RESET mid-operation aborts the operation with no done pulse.
- Priority each edge: RESET > flush > start.
- States:
  - IDLE: ready=1. An accepting edge requires start=1, flush=0 and alu_opcode in {OP_DIV, OP_DIVU, OP_REM, OP_REMU}.
    - Any other opcode: start is ignored, the unit stays IDLE and no done is produced.
    - Accept, special case: go to DONE.
    - Accept, normal case: go to CALC. Latch |a|, |b| (abs only for signed ops), the sign flags and the op type. Clear remainder, load quotient=|a|, count=0.
  - CALC: busy=1, ready=0. Each edge performs one restoring step:
    - shift {rem,quo} left by 1;
    - trial = rem - |b|;
    - if trial is non-negative (33-bit compare), rem=trial and quo[0]=1, else quo[0]=0;
    - count++.
    - On the edge where count==31 (the 32nd step): go to DONE and load result with the sign-corrected quotient or remainder.
  - DONE: done=1, busy=0, ready=0 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored.
- Latency:
  - Normal op: done is high in the cycle after the 32nd CALC edge, i.e. 33 edges after the accepting edge.
  - Special case: done is high in the cycle after the accepting edge.
- Sign rules, signed ops only:
  - Quotient is negated if sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - Unsigned ops use the raw values.
- Special cases, resolved at accept without iterating:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- flush=1 in CALC or DONE: go to IDLE on that edge and suppress done (a done already visible in that cycle is not re-emitted). result keeps its previous value. flush in IDLE also blocks start.
- Inputs may change freely after the accepting edge; only the latched copies are used.
- No combinational path from any input to any output.

Test Plan:
- Reset, then DIV a=100 b=7 -> done exactly 33 edges after accept; result=14; busy high for 32 cycles; ready returns 1 the cycle after done.
- REM a=0xFFFFFF9C (-100) b=7 -> result=0xFFFFFFFE (-2). DIVU a=0xFFFFFFFF b=2 -> 0x7FFFFFFF. REMU a=0xFFFFFFFF b=2 -> 1.
- DIV a=5 b=0 -> 0xFFFFFFFF with done one edge after accept. REMU a=0x1234 b=0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- start with alu_opcode=5'b00100 (MUL) -> ready stays 1, busy and done stay 0, result unchanged. start held high with DIV during CALC -> only one operation runs and only one done pulse.
- flush asserted at CALC cycle 10 -> IDLE next cycle, no done, result keeps the old value. A new DIV 9/3 issued right after -> 3.
- RESET asserted mid-CALC -> next cycle ready=1, busy=0, done=0, result=0. start and flush asserted together in IDLE -> nothing accepted.

Source files
------------

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit is produced per clock. Divide-by-zero and signed overflow
// are resolved when the operation is accepted, without iterating.
module rv32m_div_unit #(
    parameter int          XLEN    = 32,
    parameter logic [4:0]  OP_DIV  = 5'b01000,
    parameter logic [4:0]  OP_DIVU = 5'b01001,
    parameter logic [4:0]  OP_REM  = 5'b01010,
    parameter logic [4:0]  OP_REMU = 5'b01011
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [4:0]      alu_opcode,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  b_abs_q;
    logic [CNT_W-1:0] count_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             is_rem_q;

    logic            op_valid;
    logic            op_signed;
    logic            op_rem;
    logic            accept;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            last_step;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] final_res;

    // Two's-complement negate when requested; used for abs and sign fix-up.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] val,
                                                 input logic neg);
        return neg ? (~val + 1'b1) : val;
    endfunction

    // Decode the request and resolve the cases that never iterate.
    always_comb begin
        op_valid    = (alu_opcode == OP_DIV) || (alu_opcode == OP_DIVU) ||
                      (alu_opcode == OP_REM) || (alu_opcode == OP_REMU);
        op_signed   = (alu_opcode == OP_DIV) || (alu_opcode == OP_REM);
        op_rem      = (alu_opcode == OP_REM) || (alu_opcode == OP_REMU);
        accept      = (state_q == S_IDLE) && start && !flush && op_valid;
        div_zero    = (operand_b == '0);
        overflow    = op_signed && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (operand_b == '1);
        special     = div_zero || overflow;
        special_res = '0;
        if (div_zero)
            special_res = op_rem ? operand_a : '1;
        else if (!op_rem)
            special_res = operand_a;
        last_step   = (count_q == CNT_W'(XLEN - 1));
    end

    // One restoring step: shift, trial-subtract, keep or restore.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        trial     = shifted - {1'b0, b_abs_q};
        rem_step  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], ~trial[XLEN]};
        final_res = is_rem_q ? cond_neg(rem_step, neg_rem_q)
                             : cond_neg(quo_step, neg_quo_q);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (accept)
                    state_d = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush)
                    state_d = S_IDLE;
                else if (last_step)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, iteration registers and the held result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rem_q     <= '0;
            quo_q     <= '0;
            b_abs_q   <= '0;
            count_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            if (special) begin
                result <= special_res;
            end else begin
                rem_q     <= '0;
                quo_q     <= cond_neg(operand_a, op_signed && operand_a[XLEN-1]);
                b_abs_q   <= cond_neg(operand_b, op_signed && operand_b[XLEN-1]);
                count_q   <= '0;
                neg_quo_q <= op_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                neg_rem_q <= op_signed && operand_a[XLEN-1];
                is_rem_q  <= op_rem;
            end
        end else if ((state_q == S_CALC) && !flush) begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= count_q + 1'b1;
            if (last_step)
                result <= final_res;
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_rv32m_div_unit;

    localparam logic [4:0] OP_DIV  = 5'b01000;
    localparam logic [4:0] OP_DIVU = 5'b01001;
    localparam logic [4:0] OP_REM  = 5'b01010;
    localparam logic [4:0] OP_REMU = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b00100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [4:0]  alu_opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    rv32m_div_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .alu_opcode (alu_opcode),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .flush      (flush),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: operations resolved without iteration.
    function automatic bit m_special(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        return (b == 32'd0) ||
               (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) &&
                (b == 32'hFFFF_FFFF));
    endfunction

    // Reference: RISC-V M-extension semantics with plain arithmetic.
    function automatic logic [31:0] m_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        bit ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            OP_REM:  begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one operation, measure latency (accepting edge counts as 1) and
    // busy cycles, then check result and return to IDLE.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
        logic [31:0] exp_res;
        int exp_lat, lat, busy_cnt;
        exp_res = m_res(op, a, b);
        exp_lat = m_special(op, a, b) ? 1 : 33;
        @(negedge CLK);
        chk({tag, "_ready_before"}, 32'(ready), 32'd1);
        start = 1'b1; alu_opcode = op; operand_a = a; operand_b = b;
        @(posedge CLK); #1;
        if (!hold) start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge CLK); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
        last_res = exp_res;
        @(posedge CLK); #1;
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (hold) begin
            repeat (3) begin
                @(posedge CLK); #1;
                chk({tag, "_no_second_done"}, 32'(done | busy), 32'd0);
            end
        end
    endtask

    initial begin
        int dcnt;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        RESET = 1'b1; start = 1'b0; flush = 1'b0;
        alu_opcode = '0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge CLK); RESET = 1'b0;

        do_op("div_100_7", OP_DIV, 32'd100, 32'd7, 1'b0);
        do_op("rem_neg", OP_REM, 32'hFFFF_FF9C, 32'd7, 1'b0);
        do_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op("remu_max", OP_REMU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op("div_by0", OP_DIV, 32'd5, 32'd0, 1'b0);
        do_op("remu_by0", OP_REMU, 32'h0000_1234, 32'd0, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("div_negneg", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);

        // Non-divide opcode must be ignored.
        @(negedge CLK);
        start = 1'b1; alu_opcode = OP_MUL; operand_a = 32'd77; operand_b = 32'd3;
        repeat (5) begin
            @(posedge CLK); #1;
            chk("mul_ready", 32'(ready), 32'd1);
            chk("mul_busy_done", 32'(busy | done), 32'd0);
            chk("mul_result", result, last_res);
        end
        @(negedge CLK); start = 1'b0;

        // start held through CALC: exactly one operation.
        do_op("div_hold", OP_DIV, 32'd1000, 32'd9, 1'b1);

        // flush mid-CALC.
        @(negedge CLK);
        start = 1'b1; alu_opcode = OP_DIV; operand_a = 32'd12345; operand_b = 32'd11;
        @(posedge CLK); #1; start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK); flush = 1'b1;
        @(posedge CLK); #1;
        chk("flush_ready", 32'(ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, last_res);
        @(negedge CLK); flush = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) dcnt++;
        end
        chk("flush_no_done", 32'(dcnt), 32'd0);
        do_op("div_9_3", OP_DIV, 32'd9, 32'd3, 1'b0);

        // RESET mid-CALC.
        @(negedge CLK);
        start = 1'b1; alu_opcode = OP_DIVU; operand_a = 32'd5000; operand_b = 32'd7;
        @(posedge CLK); #1; start = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        last_res = '0;
        @(negedge CLK); RESET = 1'b0;

        // start and flush together in IDLE: nothing accepted.
        @(negedge CLK);
        start = 1'b1; flush = 1'b1; alu_opcode = OP_DIV; operand_a = 32'd8; operand_b = 32'd2;
        @(posedge CLK); #1;
        chk("sf_ready", 32'(ready), 32'd1);
        chk("sf_busy", 32'(busy), 32'd0);
        @(negedge CLK); start = 1'b0; flush = 1'b0;
        @(posedge CLK); #1;
        chk("sf_done", 32'(done), 32'd0);
        chk("sf_result", result, last_res);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            rop = OP_DIV + 5'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = 32'($urandom_range(1, 65535));
                default: rb = $urandom;
            endcase
            do_op("rand", rop, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
